// File: rtl/tiro_nave.sv
// tiro_nave: player-ship projectile generator (optional auto-fire via TIRO_AUTO_EN)
module tiro_nave #(
    parameter int DIV       = 250000,
    parameter int PASSO     = 4,
    parameter int LARG_NAVE = 33,
    parameter int Y_TOPO    = 0,
    parameter int RECARGA   = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciarJogo,
    input  logic       pausa,
    input  logic       disparo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic       acerto,
    output logic [9:0] bola_nave_x,
    output logic [9:0] bola_nave_y,
    output logic       ativa,
    output logic [7:0] n_acertos
);
    typedef enum logic [1:0] {S_PRONTO, S_VOO, S_RECARGA} estado_t;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (RECARGA > 0) ? $clog2(RECARGA + 1) : 1;

    estado_t       estado, prox, fim;
    logic [DW-1:0] div_cnt;
    logic [CW-1:0] cont;
    logic [9:0]    pos_x, pos_y;
    logic          disp_ant, rst_jogo, borda, tick, topo, entra, sai;

    assign rst_jogo = reset | reiniciarJogo;
    assign borda    = disparo & ~disp_ant;
    assign tick     = (estado != S_PRONTO) && (div_cnt == DW'(DIV - 1));
    assign topo     = {22'd0, pos_y} < 32'(Y_TOPO + PASSO);
    assign entra    = (prox == S_VOO) && (estado != S_VOO);
    assign sai      = (estado == S_VOO) && (prox != S_VOO);
`ifdef TIRO_AUTO_EN
    assign fim      = disparo ? S_VOO : S_PRONTO;
`else
    assign fim      = S_PRONTO;
`endif

    // state register; pause freezes the FSM
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo)
            estado <= S_PRONTO;
        else if (!pausa)
            estado <= prox;
    end

    // next-state: fire edge launches, hit beats top, cooldown end returns to ready (or re-fires)
    always_comb begin
        prox = estado;
        unique case (estado)
            S_PRONTO:  prox = borda ? S_VOO : S_PRONTO;
            S_VOO:     prox = (acerto || (tick && topo)) ? S_RECARGA : S_VOO;
            S_RECARGA: prox = (cont == '0) ? fim : S_RECARGA;
            default:   prox = S_PRONTO;
        endcase
    end

    // outputs come straight from registers
    always_comb begin
        ativa       = (estado == S_VOO);
        bola_nave_x = pos_x;
        bola_nave_y = pos_y;
    end

    // previous-button register keeps tracking during pause so a held button never fires on resume
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo)
            disp_ant <= 1'b1;
        else
            disp_ant <= disparo;
    end

    // step divider runs only while flying or reloading and restarts on every state change
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo)
            div_cnt <= '0;
        else if (!pausa)
            div_cnt <= (prox != estado || estado == S_PRONTO || tick) ? '0 : div_cnt + DW'(1);
    end

    // shot position: spawn at the nose, climb on ticks, park at (0,0) when leaving flight
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (!pausa) begin
            if (entra) begin
                pos_x <= x_nave + 10'(LARG_NAVE / 2);
                pos_y <= y_nave - 10'd2;
            end else if (sai) begin
                pos_x <= '0;
                pos_y <= '0;
            end else if (estado == S_VOO && tick)
                pos_y <= pos_y - 10'(PASSO);
        end
    end

    // reload cooldown in steps, loaded on entry to RECARGA
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo)
            cont <= '0;
        else if (!pausa) begin
            if (prox == S_RECARGA && estado != S_RECARGA)
                cont <= CW'(RECARGA);
            else if (estado == S_RECARGA && tick && cont != '0)
                cont <= cont - CW'(1);
        end
    end

    // saturating hit counter, only hits during flight count
    always_ff @(posedge CLOCK_50) begin
        if (rst_jogo)
            n_acertos <= '0;
        else if (!pausa && estado == S_VOO && acerto && n_acertos != 8'hFF)
            n_acertos <= n_acertos + 8'd1;
    end
endmodule

// File: tb/tb_tiro_nave.sv
// tb_tiro_nave: directed checks of tiro_nave with DIV=4, RECARGA=10
module tb_tiro_nave;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1, reiniciarJogo = 1'b0, pausa = 1'b0, disparo = 1'b0, acerto = 1'b0;
    logic [9:0] x_nave = '0, y_nave = '0;
    logic [9:0] bola_nave_x, bola_nave_y;
    logic       ativa;
    logic [7:0] n_acertos;
    int         vectors = 0, miscompares = 0;

    tiro_nave #(.DIV(4), .PASSO(4), .LARG_NAVE(33), .Y_TOPO(0), .RECARGA(10)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
        .disparo(disparo), .x_nave(x_nave), .y_nave(y_nave), .acerto(acerto),
        .bola_nave_x(bola_nave_x), .bola_nave_y(bola_nave_y), .ativa(ativa), .n_acertos(n_acertos)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_ativa", ativa, 0);
        chk("rst_x", bola_nave_x, 0);
        chk("rst_y", bola_nave_y, 0);
        chk("rst_n", n_acertos, 0);

        // launch from (300,440), climb every 4 cycles
        x_nave = 10'd300; y_nave = 10'd440;
        disparo = 1'b1; step(1); disparo = 1'b0;
        chk("spawn_ativa", ativa, 1);
        chk("spawn_x", bola_nave_x, 316);
        chk("spawn_y", bola_nave_y, 438);
        step(3);
        chk("pre_step_y", bola_nave_y, 438);
        step(1);
        chk("step1_y", bola_nave_y, 434);
        step(4);
        chk("step2_y", bola_nave_y, 430);
        chk("step2_x", bola_nave_x, 316);

        // 3-cycle hit pulse counts once
        acerto = 1'b1; step(1);
        chk("hit_ativa", ativa, 0);
        chk("hit_x", bola_nave_x, 0);
        chk("hit_y", bola_nave_y, 0);
        chk("hit_n", n_acertos, 1);
        step(2); acerto = 1'b0;
        chk("hit_once_n", n_acertos, 1);
        disparo = 1'b1; step(1); disparo = 1'b0;
        chk("fire_in_reload", ativa, 0);
        step(40);

        // top of field: 4 -> 0 -> parked, no count
        x_nave = 10'd100; y_nave = 10'd6;
        disparo = 1'b1; step(1); disparo = 1'b0;
        chk("top_spawn_x", bola_nave_x, 116);
        chk("top_spawn_y", bola_nave_y, 4);
        step(4);
        chk("top_y0", bola_nave_y, 0);
        chk("top_y0_ativa", ativa, 1);
        step(4);
        chk("top_park_ativa", ativa, 0);
        chk("top_park_y", bola_nave_y, 0);
        chk("top_park_n", n_acertos, 1);
        step(45);
        chk("top_reload_end", ativa, 0);

        // new edge, then button held through flight and cooldown
        disparo = 1'b1; step(1);
        chk("refire_ativa", ativa, 1);
        chk("refire_y", bola_nave_y, 4);
        step(8);
        chk("held_park", ativa, 0);
        step(40);
        chk("held_cool_last", ativa, 0);
        step(1);
`ifdef TIRO_AUTO_EN
        chk("auto_fire_ativa", ativa, 1);
        chk("auto_fire_y", bola_nave_y, 4);
        step(100);
        chk("auto_again_ativa", ativa, 1);
        chk("auto_again_y", bola_nave_y, 4);
`else
        chk("held_no_refire", ativa, 0);
        step(100);
        chk("held_no_refire_late", ativa, 0);
`endif
        disparo = 1'b0;
        reset = 1'b1; step(1); reset = 1'b0;
        step(1);
        chk("rst2_n", n_acertos, 0);

        // pause freezes position and divider
        x_nave = 10'd300; y_nave = 10'd440;
        disparo = 1'b1; step(1); disparo = 1'b0;
        step(2);
        pausa = 1'b1; step(50);
        chk("pause_y", bola_nave_y, 438);
        chk("pause_ativa", ativa, 1);
        acerto = 1'b1; step(1); acerto = 1'b0;
        chk("pause_hit_n", n_acertos, 0);
        chk("pause_hit_ativa", ativa, 1);
        pausa = 1'b0; step(1);
        chk("resume_y_hold", bola_nave_y, 438);
        step(1);
        chk("resume_y_step", bola_nave_y, 434);

        // accumulate 5 hits
        acerto = 1'b1; step(1); acerto = 1'b0;
        chk("hits_n1", n_acertos, 1);
        for (int i = 0; i < 4; i++) begin
            step(45);
            disparo = 1'b1; step(1); disparo = 1'b0;
            acerto = 1'b1; step(1); acerto = 1'b0;
        end
        chk("hits_n5", n_acertos, 5);
        step(45);

        // fire edge during pause is ignored, held button does not fire on resume
        pausa = 1'b1; disparo = 1'b1; step(3);
        chk("pause_fire", ativa, 0);
        pausa = 1'b0; step(1);
        chk("resume_held", ativa, 0);
        disparo = 1'b0; step(1);
        disparo = 1'b1; step(1);
        chk("fire_before_rj", ativa, 1);
        chk("n_before_rj", n_acertos, 5);

        // reiniciarJogo mid-flight with button held
        reiniciarJogo = 1'b1; step(1); reiniciarJogo = 1'b0;
        chk("rj_ativa", ativa, 0);
        chk("rj_x", bola_nave_x, 0);
        chk("rj_y", bola_nave_y, 0);
        chk("rj_n", n_acertos, 0);
        step(3);
        chk("rj_held_no_fire", ativa, 0);
        disparo = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
